// File: rtl/serial_sub2_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub2_pkg
//
// Shared definitions for the two-bits-per-cycle serial subtractor:
//   - DEFAULT_WIDTH : default operand/result width
//   - state_t       : controller state encoding (IDLE, RUN, FIN)
//   - cnt_width()   : width of the digit counter for a given operand width
// ---------------------------------------------------------------------------
package serial_sub2_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // The counter runs from WIDTH/2-1 down to 0. For a single digit
  // (WIDTH=2) $clog2 would give zero bits, so keep at least one bit.
  function automatic int cnt_width(input int width);
    return ((width / 2) > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/serial_sub2_sub_slice2.sv
// ---------------------------------------------------------------------------
// sub_slice2
//
// Combinational 2-bit ripple slice used by serial_sub2. The subtrahend
// arrives already inverted, so with cin=1 on the first digit this adds
// a + ~b + 1 = a - b one digit at a time.
//
// Ports:
//   a      in  [1:0]  minuend digit
//   b_inv  in  [1:0]  inverted subtrahend digit
//   cin    in         carry into bit 0 of the digit
//   s      out [1:0]  sum digit
//   c_mid  out        carry from bit 0 into bit 1
//   cout   out        carry out of bit 1
// ---------------------------------------------------------------------------
module sub_slice2
  import serial_sub2_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b_inv,
  input  logic       cin,
  output logic [1:0] s,
  output logic       c_mid,
  output logic       cout
);

  logic p0;
  logic p1;

  // Propagate terms for each bit position.
  assign p0 = a[0] ^ b_inv[0];
  assign p1 = a[1] ^ b_inv[1];

  // Bit 0 full adder. Its carry is exported separately because on the
  // most significant digit it is the carry into the MSB, which the
  // controller needs for signed overflow.
  assign s[0]  = p0 ^ cin;
  assign c_mid = (a[0] & b_inv[0]) | (cin & p0);

  // Bit 1 full adder, chained from bit 0.
  assign s[1] = p1 ^ c_mid;
  assign cout = (a[1] & b_inv[1]) | (c_mid & p1);

endmodule

// File: rtl/serial_sub2.sv
// ---------------------------------------------------------------------------
// serial_sub2
//
// Multi-cycle subtractor computing diff = a - b (mod 2^WIDTH), two bits
// per clock. The operation is a + ~b + 1, performed LSB digit first by a
// 2-bit ripple slice with the carry held in a register between digits.
//
// Handshake: start is sampled in IDLE or FIN. The accept edge loads the
// operands and clears the previous results. busy is high while digits are
// processed, and done pulses for one cycle when the results are ready.
// Results are held until the next accept.
//
// Parameters:
//   WIDTH   operand/result width, even and >= 2
//
// Ports:
//   clk     in               rising-edge clock
//   rst     in               asynchronous reset, active-high
//   start   in               operation request
//   a       in  [WIDTH-1:0]  minuend, captured on accept
//   b       in  [WIDTH-1:0]  subtrahend, captured on accept
//   busy    out              high while processing digits
//   done    out              one-cycle pulse when results become valid
//   diff    out [WIDTH-1:0]  a - b mod 2^WIDTH
//   borrow  out              unsigned a < b
//   ovf     out              signed overflow of a - b
//   zero    out              diff == 0
// ---------------------------------------------------------------------------
module serial_sub2
  import serial_sub2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(WIDTH / 2 - 1);

  // Refuse to build for odd or too-small widths; the digit loop assumes
  // WIDTH splits exactly into 2-bit digits.
  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_sub2: WIDTH must be even and at least 2");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [1:0]       slice_s;
  logic             slice_cmid;
  logic             slice_cout;
  logic [WIDTH-1:0] res_shift;

  // One digit of the subtraction: low two bits of each operand register
  // plus the carry left over from the previous digit.
  sub_slice2 u_slice (
    .a     (op_a[1:0]),
    .b_inv (op_b[1:0]),
    .cin   (carry),
    .s     (slice_s),
    .c_mid (slice_cmid),
    .cout  (slice_cout)
  );

  // Result register after this digit: everything moves down by two and
  // the new digit enters at the top. After WIDTH/2 digits the first
  // digit has reached bit 0. Written as shift-and-or so it also works
  // for WIDTH=2, where the whole result is a single digit.
  assign res_shift = (res >> 2) | (WIDTH'(slice_s) << (WIDTH - 2));

  // Controller, operand/result shift registers and all registered outputs.
  // done defaults low every cycle so it can only ever be a one-cycle pulse.
  // Accepting a new operation clears the visible results so stale values
  // cannot be mistaken for the new ones while busy is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            op_a   <= a;
            op_b   <= ~b;
            res    <= '0;
            carry  <= 1'b1;
            cnt    <= LAST_DIGIT;
            busy   <= 1'b1;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          op_a  <= op_a >> 2;
          op_b  <= op_b >> 2;
          res   <= res_shift;
          carry <= slice_cout;
          if (cnt == '0) begin
            // Last digit: the carry out is the inverted borrow, and the
            // carry into the MSB disagreeing with the carry out of it
            // means the signed result does not fit.
            diff   <= res_shift;
            borrow <= ~slice_cout;
            ovf    <= slice_cout ^ slice_cmid;
            zero   <= (res_shift == '0);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FIN;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub2.sv
// ---------------------------------------------------------------------------
// tb_serial_sub2
//
// Directed self-checking bench for serial_sub2 with WIDTH=8. Each scenario
// task drives its own stimulus and compares DUT outputs against
// hand-computed values. Inputs change and outputs are sampled 1 time unit
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_serial_sub2;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       ovf;
  logic       zero;

  int compared   = 0;
  int mismatched = 0;

  serial_sub2 #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf),
    .zero   (zero)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request; the caller steps to make the accept edge happen.
  task automatic applyStimulus(input logic st, input logic [7:0] ta, input logic [7:0] tb_v);
    start = st;
    a     = ta;
    b     = tb_v;
  endtask

  // Full operation: accept, four busy cycles, done on the fifth cycle
  // after the accept edge, then done must drop while results hold.
  task automatic do_op(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [7:0] ediff, input logic ebor, input logic eovf,
                       input logic ezero);
    applyStimulus(1'b1, ta, tb_v);
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      compared++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL %s run cycle %0d busy/done: got %b%b, want 10", name, c, busy, done);
      end
      step();
    end
    compared++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s fin busy/done: got %b%b, want 01", name, busy, done);
    end
    compared++;
    if (diff !== ediff) begin
      mismatched++;
      $display("[TB] FAIL %s diff: got %h, want %h", name, diff, ediff);
    end
    compared++;
    if (borrow !== ebor || ovf !== eovf || zero !== ezero) begin
      mismatched++;
      $display("[TB] FAIL %s flags borrow/ovf/zero: got %b%b%b, want %b%b%b",
               name, borrow, ovf, zero, ebor, eovf, ezero);
    end
    step();
    compared++;
    if (done !== 1'b0 || diff !== ediff) begin
      mismatched++;
      $display("[TB] FAIL %s hold: got done=%b diff=%h, want done=0 diff=%h", name, done, diff, ediff);
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00);
    step();
    step();
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || zero !== 1'b1 ||
        borrow !== 1'b0 || ovf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset values: got busy=%b done=%b diff=%h zero=%b borrow=%b ovf=%b, want 0 0 00 1 0 0",
               busy, done, diff, zero, borrow, ovf);
    end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("[TB] FAIL idle activity: got %0d busy/done cycles, want 0", pulses);
    end
  endtask

  task automatic test_basic();
    do_op("basic", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_edge_cases();
    do_op("unsigned_borrow", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0);
    do_op("signed_ovf",      8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    do_op("equal",           8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_start_in_run();
    int pulses;
    applyStimulus(1'b1, 8'h05, 8'h01);
    step();
    start = 1'b0;
    step();
    // RUN cycle 2: a new request with different operands must be ignored.
    applyStimulus(1'b1, 8'hFF, 8'h00);
    step();
    start = 1'b0;
    step();
    step();
    compared++;
    if (done !== 1'b1 || diff !== 8'h04) begin
      mismatched++;
      $display("[TB] FAIL start_in_run result: got done=%b diff=%h, want done=1 diff=04", done, diff);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("[TB] FAIL start_in_run extra op: got %0d busy/done cycles, want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 8'h09, 8'h0A);
    step();
    for (int c = 1; c <= 4; c++) step();
    // FIN of the first operation; start still high, new operands.
    a = 8'h01;
    b = 8'h01;
    compared++;
    if (done !== 1'b1 || diff !== 8'hFF || borrow !== 1'b1 || zero !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b first: got done=%b diff=%h borrow=%b zero=%b, want 1 ff 1 0",
               done, diff, borrow, zero);
    end
    step();
    compared++;
    if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'h00 || zero !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b accept: got busy=%b done=%b diff=%h zero=%b, want 1 0 00 0",
               busy, done, diff, zero);
    end
    for (int c = 2; c <= 5; c++) step();
    compared++;
    if (done !== 1'b1 || diff !== 8'h00 || zero !== 1'b1 || borrow !== 1'b0 || ovf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b second: got done=%b diff=%h zero=%b borrow=%b ovf=%b, want 1 00 1 0 0",
               done, diff, zero, borrow, ovf);
    end
    start = 1'b0;
    step();
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b release: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    applyStimulus(1'b1, 8'h77, 8'h11);
    step();
    start = 1'b0;
    step();
    step();
    // RUN cycle 3: asynchronous abort.
    rst = 1'b1;
    #1;
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || zero !== 1'b1 ||
        borrow !== 1'b0 || ovf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort values: got busy=%b done=%b diff=%h zero=%b borrow=%b ovf=%b, want 0 0 00 1 0 0",
               busy, done, diff, zero, borrow, ovf);
    end
    step();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("[TB] FAIL abort done: got %0d busy/done cycles, want 0", pulses);
    end
    do_op("after_abort", 8'h02, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    test_reset();
    test_basic();
    test_edge_cases();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_sub2.md
Name: serial_sub2

Overview:
- Multi-cycle unsigned/two's-complement subtractor computing diff = a - b over WIDTH-bit operands.
- Processes two bits per clock using a 2-bit adder-style slice with inverted b and carry-in 1.
- Sits beside the combinational adders as the area-cheap inverse operation for datapaths that tolerate latency.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be even and at least 2. Elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only in IDLE or FIN
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, high while in FIN
- diff  output  WIDTH  a - b mod 2^WIDTH; valid when done is high, held until the next accept
- borrow  output  1  1 when unsigned a < b; valid and held like diff
- ovf  output  1  signed overflow of a - b; valid and held like diff
- zero  output  1  diff == 0; valid and held like diff

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=IDLE; busy, done, borrow, ovf = 0; diff = 0; zero = 1; operand registers, digit counter and carry = 0.
- States: IDLE, RUN, FIN.
- IDLE: when start=1 at an edge, load a into shift register A and ~b into shift register B, set carry=1, set counter=WIDTH/2-1, go to RUN. The same edge clears done, diff, borrow, ovf and zero.
- RUN, each edge:
  - {c1, s1, s0} = A[1:0] + B[1:0] + carry (2-bit ripple).
  - Shift result right by 2 with {s1, s0} entering at the MSBs.
  - Shift A and B right by 2.
  - carry <= c1.
  - Also record the carry into bit 1 of the current digit (c0). On the last digit, this is the carry into the MSB.
  - If counter==0: go to FIN, and load:
    - diff = final shifted result
    - borrow = ~c1
    - ovf = c1 ^ c0(last digit)
    - zero = (final result == 0)
  - Otherwise decrement counter.
- busy=1 exactly while state==RUN.
- start is ignored in RUN. A and b changes in RUN have no effect.
- FIN: done=1 for exactly this cycle.
  - If start=1 at the next edge: accept as in IDLE and go to RUN (back-to-back supported).
  - Otherwise go to IDLE.
- Latency: accept edge E0; digits processed at E1..E(WIDTH/2); done high in the cycle following E(WIDTH/2). Issue interval is WIDTH/2+1 cycles.
- Results stay stable after FIN until the next accept edge.
- rst asserted mid-RUN aborts the operation immediately (asynchronous clear). No done pulse is produced for the aborted operation.
- a == b gives diff=0, borrow=0, zero=1, ovf=0.
- Arithmetic is full modular. No saturation.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, FIN=2'd2
  - default WIDTH constant
- One natural sub-module: sub_slice2, combinational. Inputs: a[1:0], b_inv[1:0], cin. Outputs: s[1:0], c_mid, cout. Built from the same xor/and/or full-adder structure as the team's 2-bit adder, with the carry chained through both bits.
- The FSM, counter and shift registers live in serial_sub2.

Test Plan (WIDTH=8):
- Reset then idle: rst pulse -> busy=0, done=0, diff=0x00, zero=1. No done pulse over 10 idle cycles.
- start with a=0x5A, b=0x23 -> busy high for 4 cycles. done high for exactly 1 cycle, 5 cycles after the accept edge. diff=0x37, borrow=0, ovf=0, zero=0.
- Unsigned and signed edge cases:
  - a=0x10, b=0x20 -> diff=0xF0, borrow=1, ovf=0.
  - a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1.
  - a=0x3C, b=0x3C -> diff=0x00, zero=1, borrow=0.
- Start in RUN ignored: start a=0x05, b=0x01; in RUN cycle 2 assert start with a=0xFF, b=0x00 -> single done, diff=0x04. a and b changes mid-run have no effect.
- Back-to-back: start held high continuously with a=0x09, b=0x0A, then a=0x01, b=0x01 on the FIN cycle. Expect:
  - first done: diff=0xFF, borrow=1
  - second operation accepted on the edge leaving FIN
  - second done exactly 5 cycles later: diff=0x00, zero=1
- Reset mid-operation: assert rst in RUN cycle 3 -> outputs immediately at reset values. No done pulse for the aborted operation. A following start with a=0x02, b=0x01 gives diff=0x01.
